galivan_rom_loader: RTL and testbench

GALIVAN_ROM_LOADER -- requirements
Module: galivan_rom_loader

---
 rtl/galivan_rom_loader.sv | 241 ++++++++++++++++++++++++
 tb/tb_galivan_rom_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/galivan_rom_loader.sv
// galivan_rom_loader
//   Bridges the byte-wide ioctl ROM download stream onto one or more SDRAM
//   write ports that use a toggle request/acknowledge handshake. Bytes can be
//   broadcast to every port or routed to a single port by address region.
//   They can also be packed into 16-bit even/odd pairs. The block also tracks
//   completion of the download and produces the registered reset for the core.
//
// Ports
//   clk_sys      system clock, all logic on the rising edge
//   reset        asynchronous active-high reset
//   ioctl_*      download stream: active flag, target index, byte strobe,
//                byte address and byte data
//   port_req     per-port toggle request (out)
//   port_ack     per-port toggle acknowledge (in)
//   port_a       word address shared by all ports
//   port_ds      byte strobes {hi, lo}
//   port_d       16-bit write data
//   port_we      write enable, high while this block's download is active
//   overrun      sticky flag: a byte arrived while a write was still in flight
//   rom_loaded   a download has completed and every byte has been written
//   soft_reset   user reset request
//   core_reset   registered reset for the game core
module galivan_rom_loader #(
  parameter int                     NPORTS = 2,
  parameter int                     AW     = 23,
  parameter logic [7:0]             INDEX  = 8'd0,
  parameter int                     MODE   = 0,
  parameter logic [25*NPORTS-1:0]   BASE   = {25'h10000, 25'h0},
  parameter int                     PAIR   = 0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_downl,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [NPORTS-1:0] port_req,
  input  logic [NPORTS-1:0] port_ack,
  output logic [AW-1:0]     port_a,
  output logic [1:0]        port_ds,
  output logic [15:0]       port_d,
  output logic              port_we,
  output logic              overrun,
  output logic              rom_loaded,
  input  logic              soft_reset,
  output logic              core_reset
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // Ports addressed by a byte address. In routed mode the highest region whose
  // start is not above the address wins; below the first region nothing is hit.
  function automatic logic [NPORTS-1:0] port_sel(input logic [24:0] addr);
    logic [NPORTS-1:0] sel;
    sel = '0;
    if (MODE == 0) begin
      sel = '1;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (addr >= BASE[25*i +: 25]) begin
          sel    = '0;
          sel[i] = 1'b1;
        end
      end
    end
    return sel;
  endfunction

  // Word address inside the selected region.
  function automatic logic [AW-1:0] port_word(input logic [24:0] addr);
    logic [24:0] off;
    off = addr;
    if (MODE != 0) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (addr >= BASE[25*i +: 25]) off = addr - BASE[25*i +: 25];
      end
    end
    return off[AW:1];
  endfunction

  logic [1:0]        state_q, state_d;
  logic              ioctl_wr_q, rom_init_q;
  logic              pend_valid_q, pend_valid_d;
  logic [24:0]       pend_addr_q, pend_addr_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic [NPORTS-1:0] sel_q, sel_d;
  logic [NPORTS-1:0] req_q, req_d;
  logic [AW-1:0]     port_a_q, port_a_d;
  logic [1:0]        port_ds_q, port_ds_d;
  logic [15:0]       port_d_q, port_d_d;
  logic              overrun_q, overrun_d;
  logic              fall_seen_q, fall_seen_d;
  logic              rom_loaded_q, rom_loaded_d;
  logic              core_reset_q, core_reset_d;

  logic              rom_init, wr_edge, init_rise, init_fall;
  logic [NPORTS-1:0] new_sel;

  // Byte edges only count while our own download is active, which also makes
  // an edge coinciding with the end of the download disappear.
  assign rom_init  = ioctl_downl && (ioctl_index == INDEX);
  assign wr_edge   = ioctl_wr && !ioctl_wr_q && rom_init;
  assign init_rise = rom_init && !rom_init_q;
  assign init_fall = !rom_init && rom_init_q;
  assign new_sel   = port_sel(ioctl_addr);

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    sel_d        = sel_q;
    req_d        = req_q;
    port_a_d     = port_a_q;
    port_ds_d    = port_ds_q;
    port_d_d     = port_d_q;
    overrun_d    = overrun_q;
    fall_seen_d  = fall_seen_q | init_fall;
    rom_loaded_d = rom_loaded_q;
    core_reset_d = soft_reset | ~rom_loaded_q;

    if (init_rise) overrun_d = 1'b0;

    if (state_q == ST_IDLE && !pend_valid_q && fall_seen_q) rom_loaded_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (wr_edge) begin
          if (PAIR != 0 && pend_valid_q) begin
            pend_valid_d = 1'b0;
            state_d      = ST_ISSUE;
            sel_d        = port_sel(pend_addr_q);
            port_a_d     = port_word(pend_addr_q);
            if (ioctl_addr[0] && ioctl_addr[24:1] == pend_addr_q[24:1]) begin
              port_ds_d = 2'b11;
              port_d_d  = {ioctl_dout, pend_data_q};
            end else begin
              // Orphaned even byte goes out alone; the new byte can only be
              // kept if it is itself an even byte that can wait as pending.
              port_ds_d = 2'b01;
              port_d_d  = {pend_data_q, pend_data_q};
              if (new_sel != '0) begin
                if (!ioctl_addr[0]) begin
                  pend_valid_d = 1'b1;
                  pend_addr_d  = ioctl_addr;
                  pend_data_d  = ioctl_dout;
                end else begin
                  overrun_d = 1'b1;
                end
              end
            end
          end else if (new_sel != '0) begin
            if (PAIR != 0 && !ioctl_addr[0]) begin
              pend_valid_d = 1'b1;
              pend_addr_d  = ioctl_addr;
              pend_data_d  = ioctl_dout;
            end else begin
              sel_d     = new_sel;
              port_a_d  = port_word(ioctl_addr);
              port_ds_d = {ioctl_addr[0], ~ioctl_addr[0]};
              port_d_d  = {ioctl_dout, ioctl_dout};
              state_d   = ST_ISSUE;
            end
          end
        end else if (pend_valid_q && !rom_init) begin
          // Covers a download end seen while a write was still in flight too.
          state_d = ST_FLUSH;
        end
      end
      ST_ISSUE: begin
        req_d   = req_q ^ sel_q;
        state_d = ST_WAIT;
        if (wr_edge) overrun_d = 1'b1;
      end
      ST_WAIT: begin
        if (((port_ack ^ req_q) & sel_q) == '0) state_d = ST_IDLE;
        if (wr_edge) overrun_d = 1'b1;
      end
      default: begin
        sel_d        = port_sel(pend_addr_q);
        port_a_d     = port_word(pend_addr_q);
        port_ds_d    = 2'b01;
        port_d_d     = {pend_data_q, pend_data_q};
        pend_valid_d = 1'b0;
        state_d      = ST_ISSUE;
        if (wr_edge) overrun_d = 1'b1;
      end
    endcase
  end

  // All state registers; the core reset comes out of reset asserted.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ioctl_wr_q   <= 1'b0;
      rom_init_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      sel_q        <= '0;
      req_q        <= '0;
      port_a_q     <= '0;
      port_ds_q    <= '0;
      port_d_q     <= '0;
      overrun_q    <= 1'b0;
      fall_seen_q  <= 1'b0;
      rom_loaded_q <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      ioctl_wr_q   <= ioctl_wr;
      rom_init_q   <= rom_init;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      sel_q        <= sel_d;
      req_q        <= req_d;
      port_a_q     <= port_a_d;
      port_ds_q    <= port_ds_d;
      port_d_q     <= port_d_d;
      overrun_q    <= overrun_d;
      fall_seen_q  <= fall_seen_d;
      rom_loaded_q <= rom_loaded_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign port_req   = req_q;
  assign port_a     = port_a_q;
  assign port_ds    = port_ds_q;
  assign port_d     = port_d_q;
  assign port_we    = rom_init;
  assign overrun    = overrun_q;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;

endmodule

// File: tb/tb_galivan_rom_loader.sv
// tb_galivan_rom_loader
//   Drives one shared ioctl stream into three loaders: broadcast byte writes
//   (a), region-routed byte writes (b) and broadcast paired writes (c). Each
//   loader has its own SDRAM acknowledge responder and a monitor that logs
//   every request toggle as a transaction. Directed steps compare against
//   hand-derived tables; a randomized download is compared against a
//   transaction-level model of the expected SDRAM writes.
module tb_galivan_rom_loader;

  typedef struct packed {
    logic [1:0]  mask;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } txn_t;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_downl;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        soft_reset;

  logic [1:0]  req_a, req_b, req_c;
  logic [1:0]  ack_a = 2'b00, ack_b = 2'b00, ack_c = 2'b00;
  logic [22:0] a_a, a_b, a_c;
  logic [1:0]  ds_a, ds_b, ds_c;
  logic [15:0] d_a, d_b, d_c;
  logic        we_a, we_b, we_c;
  logic        ovr_a, ovr_b, ovr_c;
  logic        loaded_a, loaded_b, loaded_c;
  logic        creset_a, creset_b, creset_c;

  logic        hold_a = 1'b0;
  int          cnt_a = 0, cnt_b = 0, cnt_c = 0;
  logic [1:0]  prev_a = 2'b00, prev_b = 2'b00, prev_c = 2'b00;

  txn_t        obs_a[$], obs_b[$], obs_c[$];
  txn_t        exp_a[$], exp_b[$], exp_c[$];
  logic [24:0] log_addr[$];
  logic [7:0]  log_data[$];

  int          checks = 0;
  int          errors = 0;
  int          bound;
  int          idx;
  int          seg_len;
  bit          pend_open;
  logic [24:0] seg_base;
  logic [24:0] cur_addr;
  logic [7:0]  cur_data;

  always #5 clk_sys = ~clk_sys;

  galivan_rom_loader #(.NPORTS(2), .AW(23), .INDEX(8'd0), .MODE(0),
                       .BASE({25'h10000, 25'h0}), .PAIR(0)) u_dut_a (
    .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .port_req(req_a), .port_ack(ack_a),
    .port_a(a_a), .port_ds(ds_a), .port_d(d_a), .port_we(we_a),
    .overrun(ovr_a), .rom_loaded(loaded_a), .soft_reset(soft_reset),
    .core_reset(creset_a));

  galivan_rom_loader #(.NPORTS(2), .AW(23), .INDEX(8'd0), .MODE(1),
                       .BASE({25'h10000, 25'h0}), .PAIR(0)) u_dut_b (
    .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .port_req(req_b), .port_ack(ack_b),
    .port_a(a_b), .port_ds(ds_b), .port_d(d_b), .port_we(we_b),
    .overrun(ovr_b), .rom_loaded(loaded_b), .soft_reset(soft_reset),
    .core_reset(creset_b));

  galivan_rom_loader #(.NPORTS(2), .AW(23), .INDEX(8'd0), .MODE(0),
                       .BASE({25'h10000, 25'h0}), .PAIR(1)) u_dut_c (
    .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .port_req(req_c), .port_ack(ack_c),
    .port_a(a_c), .port_ds(ds_c), .port_d(d_c), .port_we(we_c),
    .overrun(ovr_c), .rom_loaded(loaded_c), .soft_reset(soft_reset),
    .core_reset(creset_c));

  // SDRAM stand-ins: echo the request three cycles after it changes. The
  // responder ignores reset so an acknowledge can stay nonzero across it.
  always @(posedge clk_sys) begin
    if (!hold_a && ack_a != req_a) begin
      if (cnt_a == 2) begin ack_a <= req_a; cnt_a <= 0; end
      else cnt_a <= cnt_a + 1;
    end else cnt_a <= 0;
    if (ack_b != req_b) begin
      if (cnt_b == 2) begin ack_b <= req_b; cnt_b <= 0; end
      else cnt_b <= cnt_b + 1;
    end else cnt_b <= 0;
    if (ack_c != req_c) begin
      if (cnt_c == 2) begin ack_c <= req_c; cnt_c <= 0; end
      else cnt_c <= cnt_c + 1;
    end else cnt_c <= 0;
  end

  function automatic txn_t mk(input logic [1:0] m, input logic [22:0] a,
                              input logic [1:0] ds, input logic [15:0] d);
    txn_t t;
    t.mask = m; t.a = a; t.ds = ds; t.d = d;
    return t;
  endfunction

  // Every toggle of a request vector is one SDRAM write; the toggled bits name
  // the ports it went to.
  always @(negedge clk_sys) begin
    prev_a <= req_a;
    prev_b <= req_b;
    prev_c <= req_c;
    if (!reset && req_a !== prev_a) obs_a.push_back(mk(req_a ^ prev_a, a_a, ds_a, d_a));
    if (!reset && req_b !== prev_b) obs_b.push_back(mk(req_b ^ prev_b, a_b, ds_b, d_b));
    if (!reset && req_c !== prev_c) obs_c.push_back(mk(req_c ^ prev_c, a_c, ds_c, d_c));
  end

  // Reference: the write a byte (or byte pair) at a given address should make.
  function automatic txn_t make_txn(input int mode, input logic [24:0] addr,
                                    input logic [1:0] ds, input logic [15:0] d);
    txn_t        t;
    logic [24:0] off;
    if (mode == 0) begin
      t.mask = 2'b11; off = addr;
    end else if (addr >= 25'h10000) begin
      t.mask = 2'b10; off = addr - 25'h10000;
    end else begin
      t.mask = 2'b01; off = addr;
    end
    t.a = off[23:1]; t.ds = ds; t.d = d;
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkQueue(input string tag, input txn_t obs[$], input txn_t exp[$]);
    checkOutput({tag, "_count"}, 64'(obs.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < obs.size()) checkOutput($sformatf("%s[%0d]", tag, i), 64'(obs[i]), 64'(exp[i]));
    end
  endtask

  // One byte strobe, then enough idle time for a full handshake to finish.
  task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data);
    @(negedge clk_sys);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (10) @(negedge clk_sys);
  endtask

  initial begin
    reset       = 1'b1;
    ioctl_downl = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr    = 1'b0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    soft_reset  = 1'b0;
    repeat (3) @(negedge clk_sys);

    checkOutput("rst_req_a", req_a, 2'b00);
    checkOutput("rst_port_a", a_a, 23'd0);
    checkOutput("rst_ds_a", ds_a, 2'b00);
    checkOutput("rst_d_a", d_a, 16'h0000);
    checkOutput("rst_overrun_a", ovr_a, 1'b0);
    checkOutput("rst_loaded_a", loaded_a, 1'b0);
    checkOutput("rst_core_reset_c", creset_c, 1'b1);
    checkOutput("rst_we_a", we_a, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    $display("[TB] download for another index");
    ioctl_index = 8'd1;
    ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    checkOutput("foreign_we", we_a, 1'b0);
    applyStimulus(25'h10, 8'h11);
    applyStimulus(25'h11, 8'h22);
    ioctl_downl = 1'b0;
    repeat (10) @(negedge clk_sys);
    checkOutput("foreign_writes", 64'(obs_a.size() + obs_b.size() + obs_c.size()), 0);
    checkOutput("foreign_loaded_a", loaded_a, 1'b0);
    checkOutput("foreign_loaded_c", loaded_c, 1'b0);

    $display("[TB] directed download");
    ioctl_index = 8'd0;
    ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    checkOutput("we_active", we_a, 1'b1);

    applyStimulus(25'h3, 8'hA5);
    checkOutput("bcast_req", req_a, 2'b11);
    checkOutput("bcast_port_a", a_a, 23'd1);
    checkOutput("bcast_ds", ds_a, 2'b10);
    checkOutput("bcast_d", d_a, 16'hA5A5);

    applyStimulus(25'h10004, 8'h5A);
    checkOutput("route_req", req_b, 2'b11);
    checkOutput("route_port_a", a_b, 23'd2);
    checkOutput("route_overrun", ovr_a, 1'b0);

    applyStimulus(25'h0, 8'h12);
    applyStimulus(25'h1, 8'h34);
    checkOutput("pair_d", d_c, 16'h3412);
    checkOutput("pair_ds", ds_c, 2'b11);

    hold_a = 1'b1;
    applyStimulus(25'h5, 8'hC3);
    applyStimulus(25'h7, 8'h3C);
    checkOutput("overrun_set", ovr_a, 1'b1);
    checkOutput("overrun_other", ovr_b, 1'b0);
    checkOutput("overrun_no_toggle", 64'(obs_a.size()), 5);
    hold_a = 1'b0;
    repeat (10) @(negedge clk_sys);

    applyStimulus(25'h8, 8'h77);
    ioctl_downl = 1'b0;
    bound = 0;
    while (loaded_c !== 1'b1 && bound < 60) begin
      @(negedge clk_sys);
      bound++;
    end
    checkOutput("flush_loaded", loaded_c, 1'b1);
    checkOutput("flush_ds", ds_c, 2'b01);
    checkOutput("flush_d", d_c, 16'h7777);
    checkOutput("flush_core_reset_hold", creset_c, 1'b1);
    @(negedge clk_sys);
    checkOutput("flush_core_reset_release", creset_c, 1'b0);
    repeat (5) @(negedge clk_sys);

    exp_a = '{mk(2'b11, 23'd1, 2'b10, 16'hA5A5), mk(2'b11, 23'h8002, 2'b01, 16'h5A5A),
              mk(2'b11, 23'd0, 2'b01, 16'h1212), mk(2'b11, 23'd0, 2'b10, 16'h3434),
              mk(2'b11, 23'd2, 2'b10, 16'hC3C3), mk(2'b11, 23'd4, 2'b01, 16'h7777)};
    exp_b = '{mk(2'b01, 23'd1, 2'b10, 16'hA5A5), mk(2'b10, 23'd2, 2'b01, 16'h5A5A),
              mk(2'b01, 23'd0, 2'b01, 16'h1212), mk(2'b01, 23'd0, 2'b10, 16'h3434),
              mk(2'b01, 23'd2, 2'b10, 16'hC3C3), mk(2'b01, 23'd3, 2'b10, 16'h3C3C),
              mk(2'b01, 23'd4, 2'b01, 16'h7777)};
    exp_c = '{mk(2'b11, 23'd1, 2'b10, 16'hA5A5), mk(2'b11, 23'h8002, 2'b01, 16'h5A5A),
              mk(2'b11, 23'd0, 2'b11, 16'h3412), mk(2'b11, 23'd2, 2'b10, 16'hC3C3),
              mk(2'b11, 23'd3, 2'b10, 16'h3C3C), mk(2'b11, 23'd4, 2'b01, 16'h7777)};
    checkQueue("dir_a", obs_a, exp_a);
    checkQueue("dir_b", obs_b, exp_b);
    checkQueue("dir_c", obs_c, exp_c);
    checkOutput("overrun_sticky", ovr_a, 1'b1);

    soft_reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    checkOutput("soft_reset_on", creset_a, 1'b1);
    soft_reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    checkOutput("soft_reset_off", creset_a, 1'b0);

    $display("[TB] randomized download");
    obs_a.delete(); obs_b.delete(); obs_c.delete();
    ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    checkOutput("overrun_cleared", ovr_a, 1'b0);

    // Runs of consecutive bytes; a run may start odd only when no even byte
    // is left waiting for its partner.
    pend_open = 1'b0;
    for (int s = 0; s < 8; s++) begin
      seg_base = ($urandom_range(0, 1) != 0 ? 25'h10000 : 25'h0) + 25'($urandom_range(0, 16'hFFF0));
      if (pend_open) seg_base[0] = 1'b0;
      seg_len = $urandom_range(1, 5);
      for (int k = 0; k < seg_len; k++) begin
        cur_addr = seg_base + 25'(k);
        cur_data = 8'($urandom);
        applyStimulus(cur_addr, cur_data);
        log_addr.push_back(cur_addr);
        log_data.push_back(cur_data);
      end
      pend_open = !cur_addr[0];
    end
    ioctl_downl = 1'b0;
    repeat (40) @(negedge clk_sys);

    exp_a.delete(); exp_b.delete(); exp_c.delete();
    for (int i = 0; i < log_addr.size(); i++) begin
      exp_a.push_back(make_txn(0, log_addr[i], log_addr[i][0] ? 2'b10 : 2'b01, {log_data[i], log_data[i]}));
      exp_b.push_back(make_txn(1, log_addr[i], log_addr[i][0] ? 2'b10 : 2'b01, {log_data[i], log_data[i]}));
    end
    idx = 0;
    while (idx < log_addr.size()) begin
      if (!log_addr[idx][0] && idx + 1 < log_addr.size() && log_addr[idx+1] == log_addr[idx] + 25'd1) begin
        exp_c.push_back(make_txn(0, log_addr[idx], 2'b11, {log_data[idx+1], log_data[idx]}));
        idx += 2;
      end else begin
        exp_c.push_back(make_txn(0, log_addr[idx], log_addr[idx][0] ? 2'b10 : 2'b01,
                                 {log_data[idx], log_data[idx]}));
        idx += 1;
      end
    end
    checkQueue("rnd_a", obs_a, exp_a);
    checkQueue("rnd_b", obs_b, exp_b);
    checkQueue("rnd_c", obs_c, exp_c);
    checkOutput("rnd_overrun", {ovr_a, ovr_b, ovr_c}, 3'b000);

    $display("[TB] reset during a transfer");
    ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    hold_a = 1'b1;
    applyStimulus(25'h20, 8'h4B);
    checkOutput("abort_pending", req_a != ack_a, 1'b1);
    reset = 1'b1;
    @(negedge clk_sys);
    checkOutput("abort_req", req_a, 2'b00);
    checkOutput("abort_loaded", loaded_a, 1'b0);
    @(negedge clk_sys);
    reset = 1'b0;
    hold_a = 1'b0;
    repeat (10) @(negedge clk_sys);
    obs_a.delete();
    applyStimulus(25'h6, 8'h9E);
    exp_a = '{mk(2'b11, 23'd3, 2'b01, 16'h9E9E)};
    checkQueue("after_abort", obs_a, exp_a);
    ioctl_downl = 1'b0;
    repeat (5) @(negedge clk_sys);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
